// File: rtl/pp_ram_multi_if.sv
// pp_ram_multi_if: bus bundle between a ping-pong frame RAM and its writer/reader.
//
// Signal semantics (single clock, all sampled on the rising edge of clk):
//   wr_clk       - write strobe; one byte (wr_byte at wr_addr) is stored per cycle it is high.
//   switch       - one-cycle pulse; commits the writer page (with wr_flags) to the frame queue.
//   switch_fail  - one-cycle pulse the cycle after a rejected switch (queue was full).
//   rd_done      - one-cycle pulse; releases the oldest committed frame (ignored when empty).
//   rd_done_all  - one-cycle pulse; releases every committed frame (overrides rd_done).
//   rd_byte      - data for rd_addr, valid one cycle after rd_addr is presented.
//   rd_flags/rd_len/unread/pending_cnt/full - describe the oldest committed frame and queue depth.
//
// Modports:
//   master - the writer/reader side (drives strobes and addresses)
//   slave  - the RAM itself
interface pp_ram_multi_if #(
    parameter int PAGE_NUM = 4,
    parameter int ADDR_W   = 8,
    parameter int FLAG_W   = 8
);
    localparam int CW = $clog2(PAGE_NUM);

    logic [7:0]        wr_byte;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_clk;
    logic [FLAG_W-1:0] wr_flags;
    logic              switch;
    logic              switch_fail;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_byte;
    logic [FLAG_W-1:0] rd_flags;
    logic [ADDR_W:0]   rd_len;
    logic              rd_done;
    logic              rd_done_all;
    logic              unread;
    logic [CW-1:0]     pending_cnt;
    logic              full;

    modport master (
        output wr_byte, wr_addr, wr_clk, wr_flags, switch, rd_addr, rd_done, rd_done_all,
        input  switch_fail, rd_byte, rd_flags, rd_len, unread, pending_cnt, full
    );

    modport slave (
        input  wr_byte, wr_addr, wr_clk, wr_flags, switch, rd_addr, rd_done, rd_done_all,
        output switch_fail, rd_byte, rd_flags, rd_len, unread, pending_cnt, full
    );
endinterface

// File: rtl/pp_ram_multi.sv
// pp_ram_multi: PAGE_NUM-page frame RAM. One page belongs to the writer; the
// other pages form an in-order queue of committed frames drained by the reader.
// Each committed page carries a flags word and an automatically captured length.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - pp_ram_multi_if.slave (write port, commit/release strobes,
//            registered read port, frame metadata and queue status)
module pp_ram_multi #(
    parameter int PAGE_NUM = 4,
    parameter int ADDR_W   = 8,
    parameter int FLAG_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    pp_ram_multi_if.slave       bus
);
    localparam int              CW      = $clog2(PAGE_NUM);
    localparam int              DEPTH   = PAGE_NUM << ADDR_W;
    localparam logic [CW-1:0]   CNT_MAX = CW'(PAGE_NUM - 1);

    logic [7:0]        mem [DEPTH];

    logic [CW-1:0]     wp;
    logic [CW-1:0]     rp;
    logic [CW-1:0]     cnt;
    logic [ADDR_W:0]   wr_len;
    logic [FLAG_W-1:0] flags_q [PAGE_NUM];
    logic [ADDR_W:0]   len_q   [PAGE_NUM];
    logic [7:0]        rd_byte_q;
    logic              sw_fail_q;
    logic              unread_q;
    logic              full_q;

    logic [ADDR_W:0]   wr_len_eff;
    logic [ADDR_W:0]   wr_addr_p1;
    logic [CW-1:0]     rp_free;
    logic [CW-1:0]     cnt_free;
    logic              commit;
    logic              reject;
    logic [CW-1:0]     cnt_n;
    logic [CW-1:0]     wp_n;

    // Releases are resolved first; the switch then sees the post-release
    // count, so a release and a commit in the same cycle never collide.
    always_comb begin
        wr_addr_p1 = {1'b0, bus.wr_addr} + (ADDR_W+1)'(1);
        wr_len_eff = wr_len;
        // A write in the commit cycle still counts toward the committed length.
        if (bus.wr_clk && (wr_addr_p1 > wr_len)) begin
            wr_len_eff = wr_addr_p1;
        end

        rp_free  = rp;
        cnt_free = cnt;
        if (bus.rd_done_all) begin
            rp_free  = wp;
            cnt_free = '0;
        end else if (bus.rd_done && (cnt != '0)) begin
            rp_free  = rp + CW'(1);
            cnt_free = cnt - CW'(1);
        end

        commit = bus.switch && (cnt_free != CNT_MAX);
        reject = bus.switch && (cnt_free == CNT_MAX);
        cnt_n  = commit ? cnt_free + CW'(1) : cnt_free;
        wp_n   = commit ? wp + CW'(1) : wp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            wr_len    <= '0;
            sw_fail_q <= 1'b0;
            unread_q  <= 1'b0;
            full_q    <= 1'b0;
            for (int i = 0; i < PAGE_NUM; i++) begin
                flags_q[i] <= '0;
                len_q[i]   <= '0;
            end
        end else begin
            wp        <= wp_n;
            rp        <= rp_free;
            cnt       <= cnt_n;
            sw_fail_q <= reject;
            unread_q  <= (cnt_n != '0);
            full_q    <= (cnt_n == CNT_MAX);
            // A rejected frame is dropped: the writer page is simply reused.
            wr_len    <= bus.switch ? '0 : wr_len_eff;
            if (commit) begin
                flags_q[wp] <= bus.wr_flags;
                len_q[wp]   <= wr_len_eff;
            end
        end
    end

    // Storage is kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.wr_clk) begin
            mem[{wp, bus.wr_addr}] <= bus.wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_byte_q <= '0;
        end else begin
            rd_byte_q <= mem[{rp, bus.rd_addr}];
        end
    end

    assign bus.rd_byte     = rd_byte_q;
    assign bus.rd_flags    = flags_q[rp];
    assign bus.rd_len      = len_q[rp];
    assign bus.switch_fail = sw_fail_q;
    assign bus.pending_cnt = cnt;
    assign bus.unread      = unread_q;
    assign bus.full        = full_q;
endmodule

// File: tb/tb_pp_ram_multi.sv
// tb_pp_ram_multi: bench for pp_ram_multi. The driver applies one set of inputs
// per cycle on the falling edge and pushes the response the frame-queue model
// predicts; the monitor pops one entry per rising edge and compares.
module tb_pp_ram_multi;
    localparam int PAGE_NUM = 4;
    localparam int ADDR_W   = 8;
    localparam int FLAG_W   = 8;
    localparam int CW       = $clog2(PAGE_NUM);

    typedef struct packed {
        logic              sw_fail;
        logic              unread;
        logic              full;
        logic [CW-1:0]     cnt;
        logic              meta_chk;
        logic [FLAG_W-1:0] flags;
        logic [ADDR_W:0]   len;
        logic              rd_chk;
        logic [7:0]        rd_byte;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic clk;
    logic reset;
    pp_ram_multi_if #(.PAGE_NUM(PAGE_NUM), .ADDR_W(ADDR_W), .FLAG_W(FLAG_W)) bus ();

    pp_ram_multi #(.PAGE_NUM(PAGE_NUM), .ADDR_W(ADDR_W), .FLAG_W(FLAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: queue of committed frames ----------------
    int                q_ser[$];   // frame serial numbers, oldest first
    logic [FLAG_W-1:0] q_flg[$];
    int                q_len[$];
    logic [7:0]        fd [int];   // bytes written per frame, keyed serial*1024+addr
    int                cur_ser;
    int                next_ser;
    int                cur_len;

    logic [EXP_W-1:0]  exp_q[$];
    int                checks;
    int                failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic we, input int wa, input logic [7:0] wd,
                         input logic [7:0] wf, input logic sw, input logic dn, input logic dna,
                         input int ra);
        exp_t e;
        int   k;
        @(negedge clk);
        reset           = r;
        bus.wr_clk      = we;
        bus.wr_addr     = wa[ADDR_W-1:0];
        bus.wr_byte     = wd;
        bus.wr_flags    = wf;
        bus.switch      = sw;
        bus.rd_done     = dn;
        bus.rd_done_all = dna;
        bus.rd_addr     = ra[ADDR_W-1:0];
        e = '0;
        if (r) begin
            q_ser.delete();
            q_flg.delete();
            q_len.delete();
            cur_ser = next_ser;
            next_ser++;
            cur_len    = 0;
            e.meta_chk = 1'b1;
            e.rd_chk   = 1'b1;
        end else begin
            if (q_ser.size() > 0) begin
                k = q_ser[0] * 1024 + ra;
                if (fd.exists(k)) begin
                    e.rd_chk  = 1'b1;
                    e.rd_byte = fd[k];
                end
            end
            if (we) begin
                fd[cur_ser * 1024 + wa] = wd;
                if (wa + 1 > cur_len) cur_len = wa + 1;
            end
            if (dna) begin
                q_ser.delete();
                q_flg.delete();
                q_len.delete();
            end else if (dn && q_ser.size() > 0) begin
                void'(q_ser.pop_front());
                void'(q_flg.pop_front());
                void'(q_len.pop_front());
            end
            if (sw) begin
                if (q_ser.size() < PAGE_NUM - 1) begin
                    q_ser.push_back(cur_ser);
                    q_flg.push_back(wf);
                    q_len.push_back(cur_len);
                end else begin
                    e.sw_fail = 1'b1;
                end
                cur_ser = next_ser;
                next_ser++;
                cur_len = 0;
            end
            e.cnt    = CW'(q_ser.size());
            e.unread = (q_ser.size() != 0);
            e.full   = (q_ser.size() == PAGE_NUM - 1);
            if (q_ser.size() > 0) begin
                e.meta_chk = 1'b1;
                e.flags    = q_flg[0];
                e.len      = (ADDR_W+1)'(q_len[0]);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    endtask
    task automatic idle(input int ra);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, ra);
    endtask
    task automatic wr(input int a, input logic [7:0] d);
        drive(0, 1, a, d, 8'h00, 0, 0, 0, 0);
    endtask
    task automatic commit(input logic [7:0] f);
        drive(0, 0, 0, 8'h00, f, 1, 0, 0, 0);
    endtask
    task automatic done(input int ra);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, ra);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_t'(exp_q.pop_front());
                check("switch_fail", 32'(bus.switch_fail), 32'(e.sw_fail));
                check("unread", 32'(bus.unread), 32'(e.unread));
                check("full", 32'(bus.full), 32'(e.full));
                check("pending_cnt", 32'(bus.pending_cnt), 32'(e.cnt));
                if (e.meta_chk) begin
                    check("rd_flags", 32'(bus.rd_flags), 32'(e.flags));
                    check("rd_len", 32'(bus.rd_len), 32'(e.len));
                end
                if (e.rd_chk) check("rd_byte", 32'(bus.rd_byte), 32'(e.rd_byte));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ra;
        checks   = 0;
        failures = 0;
        next_ser = 1;
        cur_ser  = 0;
        cur_len  = 0;
        reset           = 1'b1;
        bus.wr_clk      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_byte     = '0;
        bus.wr_flags    = '0;
        bus.switch      = 1'b0;
        bus.rd_done     = 1'b0;
        bus.rd_done_all = 1'b0;
        bus.rd_addr     = '0;

        do_reset();
        do_reset();
        idle(0);

        // basic frame: three bytes, flags A5, read back address 1
        wr(0, 8'h11);
        wr(1, 8'h22);
        wr(2, 8'h33);
        commit(8'hA5);
        idle(1);
        idle(2);

        // fill to full, including a maximum-length (256-byte) frame
        wr(0, 8'h40);
        wr(1, 8'h41);
        commit(8'h02);
        wr(3, 8'h50);
        wr(255, 8'hFF);
        commit(8'h03);
        idle(0);
        // rejected switch: a write in that cycle lands in the dropped frame
        drive(0, 1, 7, 8'hEE, 8'h04, 1, 0, 0, 0);
        idle(0);
        idle(0);
        // release one, then a frame with only address 5 written
        done(0);
        wr(5, 8'h55);
        commit(8'h06);
        idle(1);

        // drain in commit order; extra rd_done on an empty queue
        done(1);
        idle(255);
        done(3);
        idle(5);
        done(5);
        done(0);
        idle(0);

        // full queue: rd_done + switch (+write) in the same cycle
        wr(0, 8'h61); commit(8'h11);
        wr(0, 8'h62); commit(8'h12);
        wr(0, 8'h63); commit(8'h13);
        drive(0, 1, 1, 8'h64, 8'h14, 1, 1, 0, 0);
        idle(0);
        done(0); done(0); done(0);
        idle(1);

        // two pending, rd_done_all + switch together
        wr(0, 8'h71); commit(8'h21);
        wr(0, 8'h72); commit(8'h22);
        wr(2, 8'h73);
        drive(0, 1, 4, 8'h74, 8'h77, 1, 0, 1, 0);
        idle(2);
        idle(4);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);

        // 20 commit/release rounds to wrap the pointers
        for (int i = 0; i < 20; i++) begin
            wr(i % 8, 8'($urandom_range(0, 255)));
            wr(8 + (i % 4), 8'($urandom_range(0, 255)));
            commit(8'(8'h80 + i));
            idle(i % 8);
            done(8 + (i % 4));
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (q_ser.size() > 0 && q_len[0] > 0) ra = $urandom_range(0, q_len[0] - 1);
            else ra = $urandom_range(0, 255);
            drive(0,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 15),
                  8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 29) == 0),
                  ra);
        end

        // reset in the middle of a frame; post-reset length ignores earlier writes
        wr(0, 8'h91); commit(8'h31);
        wr(10, 8'h92);
        wr(11, 8'h93);
        do_reset();
        idle(0);
        wr(3, 8'hA3);
        commit(8'h41);
        idle(3);
        idle(0);

        @(posedge clk);
        @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
